// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I-subset sequencer.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {INST_R, INST_I, INST_B, INST_J, INST_U} inst_type_t;

    typedef enum logic [3:0] {
        ADD, SUB, SLL, SLT, XOR, SRL, SRA, OR, AND, EQL, ADDI
    } ALU_func_t;

    typedef enum logic [1:0] {
        WB_ALU    = 2'd0,
        WB_PC4    = 2'd1,
        WB_IMM    = 2'd2,
        WB_TARGET = 2'd3
    } wb_sel_t;

    typedef enum logic [1:0] {
        FC_NONE     = 2'b00,
        FC_ILLEGAL  = 2'b01,
        FC_TIMEOUT  = 2'b10,
        FC_MISALIGN = 2'b11
    } fault_cause_t;

    typedef enum logic [2:0] {
        R_ADDSUB = 3'b000, R_SLL = 3'b001, R_SLT = 3'b010, R_SLTU   = 3'b011,
        R_XOR    = 3'b100, R_SRLSRA = 3'b101, R_OR = 3'b110, R_AND  = 3'b111
    } R_funct3_t;

    typedef enum logic [2:0] {
        I_ADDI = 3'b000, I_SLLI = 3'b001, I_SLTI = 3'b010, I_SLTIU    = 3'b011,
        I_XORI = 3'b100, I_SRLSRAI = 3'b101, I_ORI = 3'b110, I_ANDI  = 3'b111
    } I_funct3_t;

    typedef enum logic [2:0] {
        B_BEQ = 3'b000, B_BNE = 3'b001, B_BLT = 3'b100, B_BGE = 3'b101
    } B_funct3_t;

    // Sequencer state kept as plain constants so existing encodings stay bit-compatible
    typedef logic [2:0] ctrl_state_t;
    localparam ctrl_state_t FETCH      = 3'd0;
    localparam ctrl_state_t FETCH_WAIT = 3'd1;
    localparam ctrl_state_t DECODE     = 3'd2;
    localparam ctrl_state_t EXECUTE    = 3'd3;
    localparam ctrl_state_t WRITEBACK  = 3'd4;
    localparam ctrl_state_t FAULT      = 3'd5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction-memory fetch port: one-cycle request pulse, response strobe.
interface multicycle_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;

    modport master (output imem_req, output imem_addr, input imem_rdata, input imem_valid);
    modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_valid);
endinterface

// File: rtl/multicycle_ctrl_decoder.sv
// Combinational instruction classifier: class, ALU op, operand select, writeback source.
module instr_decoder
    import multicycle_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output inst_type_t  inst_type,
    output ALU_func_t   alu_func,
    output logic        alu_src_imm,
    output wb_sel_t     wb_sel,
    output logic        is_branch,
    output logic        illegal
);
    logic [6:0] opcode;
    logic [6:0] funct7;
    logic       alt;
    R_funct3_t  r_f3;
    I_funct3_t  i_f3;
    B_funct3_t  b_f3;
    logic       unused_fields;

    assign opcode        = instr[6:0];
    assign funct7        = instr[31:25];
    assign alt           = (funct7 == F7_ALT);
    assign r_f3          = R_funct3_t'(instr[14:12]);
    assign i_f3          = I_funct3_t'(instr[14:12]);
    assign b_f3          = B_funct3_t'(instr[14:12]);
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    // Map opcode/funct3/funct7 to controls; anything outside the supported subset is illegal
    always_comb begin
        inst_type   = INST_R;
        alu_func    = ADD;
        alu_src_imm = 1'b0;
        wb_sel      = WB_ALU;
        is_branch   = 1'b0;
        illegal     = 1'b0;
        case (opcode)
            OPC_OP: begin
                case (r_f3)
                    R_ADDSUB: alu_func = alt ? SUB : ADD;
                    R_SLL:    alu_func = SLL;
                    R_SLT:    alu_func = SLT;
                    R_XOR:    alu_func = XOR;
                    R_SRLSRA: alu_func = alt ? SRA : SRL;
                    R_OR:     alu_func = OR;
                    R_AND:    alu_func = AND;
                    default:  illegal  = 1'b1;
                endcase
                if (!(funct7 == F7_ZERO || (alt && (r_f3 == R_ADDSUB || r_f3 == R_SRLSRA))))
                    illegal = 1'b1;
            end
            OPC_OPIMM: begin
                inst_type   = INST_I;
                alu_src_imm = 1'b1;
                case (i_f3)
                    I_ADDI: alu_func = ADDI;
                    I_SLTI: alu_func = SLT;
                    I_XORI: alu_func = XOR;
                    I_ORI:  alu_func = OR;
                    I_ANDI: alu_func = AND;
                    I_SLLI: begin
                        alu_func = SLL;
                        illegal  = (funct7 != F7_ZERO);
                    end
                    I_SRLSRAI: begin
                        alu_func = alt ? SRA : SRL;
                        illegal  = !(alt || funct7 == F7_ZERO);
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OPC_BRANCH: begin
                inst_type = INST_B;
                is_branch = 1'b1;
                case (b_f3)
                    B_BEQ, B_BNE: alu_func = EQL;
                    B_BLT, B_BGE: alu_func = SLT;
                    default:      illegal  = 1'b1;
                endcase
            end
            OPC_JAL: begin
                inst_type = INST_J;
                wb_sel    = WB_PC4;
            end
            OPC_LUI: begin
                inst_type = INST_U;
                wb_sel    = WB_IMM;
            end
            OPC_AUIPC: begin
                inst_type = INST_U;
                wb_sel    = WB_TARGET;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: fetch, decode, execute, writeback with PC ownership and sticky fault.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int unsigned FETCH_TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    multicycle_ctrl_if.master        imem,
    output logic [31:0]              pc,
    output logic [31:0]              instr,
    output inst_type_t               inst_type,
    output ALU_func_t                alu_func,
    output logic                     alu_src_imm,
    input  logic                     alu_flag,
    input  logic [31:0]              target,
    output wb_sel_t                  wb_sel,
    output logic                     rf_we,
    output logic                     retire,
    output logic                     fault,
    output fault_cause_t             fault_cause
);
    ctrl_state_t state;
    logic [31:0] wait_cnt;
    logic        flag_q;
    logic        is_branch;
    logic        illegal;
    logic        taken;
    logic        redirect;
    logic        misaligned;

    instr_decoder u_dec (
        .instr       (instr),
        .inst_type   (inst_type),
        .alu_func    (alu_func),
        .alu_src_imm (alu_src_imm),
        .wb_sel      (wb_sel),
        .is_branch   (is_branch),
        .illegal     (illegal)
    );

    // funct3[0] set (bne/bge) means the branch is taken on the inverted compare result
    assign taken      = is_branch && (flag_q ^ instr[12]);
    assign redirect   = (inst_type == INST_J) || taken;
    assign misaligned = redirect && (target[1:0] != 2'b00);

    assign imem.imem_req  = (state == FETCH) && !rst;
    assign imem.imem_addr = pc;
    assign retire         = (state == WRITEBACK) && !misaligned;
    assign rf_we          = retire && !is_branch && (instr[11:7] != 5'd0);

    // Sequencer, PC, instruction register, fetch timeout and sticky fault
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            instr       <= '0;
            fault       <= 1'b0;
            fault_cause <= FC_NONE;
            wait_cnt    <= '0;
            flag_q      <= 1'b0;
        end else begin
            case (state)
                FETCH: state <= FETCH_WAIT;
                FETCH_WAIT: begin
                    if (imem.imem_valid) begin
                        instr    <= imem.imem_rdata;
                        wait_cnt <= '0;
                        state    <= DECODE;
                    end else if (FETCH_TIMEOUT != 0 && wait_cnt + 32'd1 == FETCH_TIMEOUT) begin
                        fault       <= 1'b1;
                        fault_cause <= FC_TIMEOUT;
                        state       <= FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                DECODE: begin
                    if (illegal) begin
                        fault       <= 1'b1;
                        fault_cause <= FC_ILLEGAL;
                        state       <= FAULT;
                    end else begin
                        state <= EXECUTE;
                    end
                end
                EXECUTE: begin
                    flag_q <= alu_flag;
                    state  <= WRITEBACK;
                end
                WRITEBACK: begin
                    if (misaligned) begin
                        fault       <= 1'b1;
                        fault_cause <= FC_MISALIGN;
                        state       <= FAULT;
                    end else begin
                        pc    <= redirect ? target : pc + 32'd4;
                        state <= FETCH;
                    end
                end
                FAULT:   state <= FAULT;
                default: state <= FAULT;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench: directed scenarios plus randomized legal instructions vs. a reference model.
`timescale 1ns/1ps
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam int unsigned TIMEOUT = 8;

    logic         clk;
    logic         rst;
    logic [31:0]  pc;
    logic [31:0]  instr;
    inst_type_t   inst_type;
    ALU_func_t    alu_func;
    logic         alu_src_imm;
    logic         alu_flag;
    logic [31:0]  target;
    wb_sel_t      wb_sel;
    logic         rf_we;
    logic         retire;
    logic         fault;
    fault_cause_t fault_cause;

    int unsigned  checks = 0;
    int unsigned  errors = 0;
    logic [31:0]  mpc;

    multicycle_ctrl_if imem_bus ();

    multicycle_ctrl #(.RESET_PC(RST_PC), .FETCH_TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (imem_bus),
        .pc          (pc),
        .instr       (instr),
        .inst_type   (inst_type),
        .alu_func    (alu_func),
        .alu_src_imm (alu_src_imm),
        .alu_flag    (alu_flag),
        .target      (target),
        .wb_sel      (wb_sel),
        .rf_we       (rf_we),
        .retire      (retire),
        .fault       (fault),
        .fault_cause (fault_cause)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200us");
        $fatal(1);
    end

    typedef struct {
        bit          illegal;
        inst_type_t  ty;
        ALU_func_t   fn;
        bit          imm;
        wb_sel_t     wb;
        bit          we;
        bit          misaligned;
        logic [31:0] next_pc;
    } expect_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: what the instruction means architecturally, independent of any state machine
    function automatic expect_t predict(input logic [31:0] w, input logic [31:0] tgt,
                                        input logic flag, input logic [31:0] cur);
        expect_t     e;
        logic [6:0]  op;
        logic [6:0]  f7;
        logic [2:0]  f3;
        bit          alt;
        bit          jump;
        ALU_func_t   base [8];
        base = '{ADD, SLL, SLT, ADD, XOR, SRL, OR, AND};
        op  = w[6:0];
        f3  = w[14:12];
        f7  = w[31:25];
        alt = (f7 == 7'h20);
        jump = 1'b0;
        e.illegal = 1'b0; e.ty = INST_R; e.fn = ADD; e.imm = 1'b0; e.wb = WB_ALU; e.we = 1'b0;
        if (op == 7'h33) begin
            e.fn = base[f3];
            if (alt && f3 == 3'd0) e.fn = SUB;
            if (alt && f3 == 3'd5) e.fn = SRA;
            e.we = 1'b1;
            e.illegal = (f3 == 3'd3) || !(f7 == 7'h00 || (alt && (f3 == 3'd0 || f3 == 3'd5)));
        end else if (op == 7'h13) begin
            e.ty = INST_I; e.imm = 1'b1; e.we = 1'b1;
            e.fn = (f3 == 3'd0) ? ADDI : base[f3];
            if (f3 == 3'd5 && alt) e.fn = SRA;
            e.illegal = (f3 == 3'd3) || (f3 == 3'd1 && f7 != 7'h00) ||
                        (f3 == 3'd5 && !(f7 == 7'h00 || alt));
        end else if (op == 7'h63) begin
            e.ty = INST_B;
            e.fn = (f3 < 3'd4) ? EQL : SLT;
            e.illegal = (f3 == 3'd2 || f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
            jump = (f3 == 3'd0 || f3 == 3'd4) ? flag : !flag;
        end else if (op == 7'h6F) begin
            e.ty = INST_J; e.wb = WB_PC4; e.we = 1'b1; jump = 1'b1;
        end else if (op == 7'h37) begin
            e.ty = INST_U; e.wb = WB_IMM; e.we = 1'b1;
        end else if (op == 7'h17) begin
            e.ty = INST_U; e.wb = WB_TARGET; e.we = 1'b1;
        end else begin
            e.illegal = 1'b1;
        end
        e.misaligned = jump && (tgt[1:0] != 2'b00);
        e.we         = e.we && (w[11:7] != 5'd0) && !e.misaligned;
        e.next_pc    = e.misaligned ? cur : (jump ? tgt : cur + 32'd4);
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [2:0]  f3;
        int unsigned k;
        w  = $urandom;
        k  = $urandom_range(0, 5);
        f3 = 3'($urandom_range(0, 7));
        if (f3 == 3'd3) f3 = 3'd0;
        case (k)
            0: begin
                w[6:0] = 7'h33; w[14:12] = f3;
                w[31:25] = ((f3 == 3'd0 || f3 == 3'd5) && w[30]) ? 7'h20 : 7'h00;
            end
            1: begin
                w[6:0] = 7'h13; w[14:12] = f3;
                if (f3 == 3'd1) w[31:25] = 7'h00;
                if (f3 == 3'd5) w[31:25] = w[30] ? 7'h20 : 7'h00;
            end
            2: begin
                w[6:0] = 7'h63; w[13] = 1'b0;
            end
            3: w[6:0] = 7'h6F;
            4: w[6:0] = 7'h37;
            default: w[6:0] = 7'h17;
        endcase
        return w;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        imem_bus.imem_valid = 1'b0;
        #1;
        check("rst_pc", pc, RST_PC);
        check("rst_instr", instr, 32'h0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_cause", 32'(fault_cause), 32'(FC_NONE));
        check("rst_req", 32'(imem_bus.imem_req), 32'd0);
        check("rst_pulses", 32'({rf_we, retire}), 32'd0);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        mpc = RST_PC;
    endtask

    task automatic wait_req(output bit got);
        got = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (imem_bus.imem_req) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("req_seen", 32'(got), 32'd1);
    endtask

    // Serve one fetch after `lat` cycles and follow the instruction to the next fetch
    task automatic run_instr(input logic [31:0] w, input logic [31:0] tgt, input logic flag,
                             input int unsigned lat, output bit faulted);
        expect_t     e;
        bit          got;
        int unsigned we_cnt;
        int unsigned ret_cnt;
        faulted = 1'b0;
        we_cnt  = 0;
        ret_cnt = 0;
        target  = tgt;
        wait_req(got);
        if (!got) begin
            faulted = 1'b1;
            return;
        end
        e = predict(w, tgt, flag, mpc);
        check("fetch_addr", imem_bus.imem_addr, mpc);
        for (int unsigned cyc = 1; cyc <= lat + 4; cyc++) begin
            @(negedge clk);
            we_cnt  += rf_we ? 1 : 0;
            ret_cnt += retire ? 1 : 0;
            imem_bus.imem_valid = (cyc == lat);
            imem_bus.imem_rdata = (cyc == lat) ? w : $urandom;
            alu_flag = (cyc == lat + 2) ? flag : !flag;
            if (cyc == lat + 1) begin
                check("instr", instr, w);
                check("inst_type", 32'(inst_type), 32'(e.ty));
                if (e.ty == INST_R || e.ty == INST_I || e.ty == INST_B) begin
                    if (!e.illegal) check("alu_func", 32'(alu_func), 32'(e.fn));
                    check("alu_src_imm", 32'(alu_src_imm), 32'(e.imm));
                end
                if (e.ty != INST_B && !e.illegal) check("wb_sel", 32'(wb_sel), 32'(e.wb));
            end
            if (cyc == lat + 2 && e.illegal) begin
                check("illegal_fault", 32'(fault), 32'd1);
                check("illegal_cause", 32'(fault_cause), 32'(FC_ILLEGAL));
                faulted = 1'b1;
                return;
            end
            if (cyc == lat + 3) begin
                check("wb_rf_we", 32'(rf_we), 32'(e.we));
                check("wb_retire", 32'(retire), 32'(!e.misaligned));
                if (e.ty != INST_J && e.ty != INST_U)
                    check("alu_func_wb", 32'(alu_func), 32'(e.fn));
            end
            if (cyc == lat + 4) begin
                check("next_pc", pc, e.next_pc);
                check("fault_after", 32'(fault), 32'(e.misaligned));
                if (e.misaligned)
                    check("misalign_cause", 32'(fault_cause), 32'(FC_MISALIGN));
                else
                    check("next_req", 32'(imem_bus.imem_req), 32'd1);
            end
        end
        check("we_pulses", we_cnt, 32'(e.we));
        check("retire_pulses", ret_cnt, 32'(!e.misaligned));
        faulted = e.misaligned;
        if (!faulted) mpc = e.next_pc;
    endtask

    initial begin
        bit          f;
        bit          got;
        int unsigned n;
        logic [31:0] t;
        rst = 1'b0;
        alu_flag = 1'b0;
        target = '0;
        imem_bus.imem_valid = 1'b0;
        imem_bus.imem_rdata = '0;
        mpc = RST_PC;

        apply_reset();

        // Directed: ADD, SUB to x0, BNE both ways at pc 8
        run_instr(32'h002081B3, 32'h0000_0000, 1'b0, 1, f);
        run_instr(32'h40208033, 32'h0000_0000, 1'b0, 1, f);
        run_instr(32'h00209063, 32'h0000_0040, 1'b1, 2, f);
        run_instr(32'h0000006F, 32'h0000_0008, 1'b0, 1, f);
        run_instr(32'h00209063, 32'h0000_0040, 1'b0, 1, f);
        check("bne_taken_pc", pc, 32'h0000_0040);

        // Reset in the middle of FETCH_WAIT
        wait_req(got);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_req", 32'(imem_bus.imem_req), 32'd0);
        check("mid_rst_pc", pc, RST_PC);
        check("mid_rst_pulses", 32'({rf_we, retire, fault}), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_req_after", 32'(imem_bus.imem_req), 32'd1);
        check("mid_rst_addr_after", imem_bus.imem_addr, RST_PC);
        mpc = RST_PC;

        // Randomized legal instruction stream
        for (int i = 0; i < 40; i++) begin
            t = $urandom;
            t[1:0] = 2'b00;
            run_instr(rand_instr(), t, 1'($urandom), $urandom_range(1, 3), f);
        end

        // PC wrap at the top of the address space
        run_instr(32'h0000006F, 32'hFFFF_FFFC, 1'b0, 1, f);
        run_instr(32'h002081B3, 32'h0000_0000, 1'b0, 1, f);
        check("wrap_pc", pc, 32'h0000_0000);

        // Misaligned JAL target: no writeback, pc held, fault is absorbing
        run_instr(32'h002081B3, 32'h0000_0000, 1'b0, 1, f);
        run_instr(32'h000000EF, 32'h0000_0102, 1'b0, 1, f);
        check("misalign_flag", 32'(f), 32'd1);
        n = 0;
        repeat (10) begin
            @(negedge clk);
            n += (imem_bus.imem_req || rf_we || retire) ? 1 : 0;
        end
        check("misalign_quiet", n, 32'd0);
        check("misalign_pc", pc, 32'h0000_0004);
        check("misalign_sticky", 32'(fault_cause), 32'(FC_MISALIGN));
        apply_reset();

        // Illegal word: fault cause 01, no further fetches
        run_instr(32'h00500093, 32'h0000_0000, 1'b0, 1, f);
        run_instr(32'h0000007F, 32'h0000_0000, 1'b0, 2, f);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            n += imem_bus.imem_req ? 1 : 0;
        end
        check("illegal_no_req", n, 32'd0);
        check("illegal_pc_hold", pc, 32'h0000_0004);
        check("illegal_instr_hold", instr, 32'h0000_007F);
        apply_reset();

        // Fetch timeout with imem_valid held low
        check("to_req", 32'(imem_bus.imem_req), 32'd1);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (fault) break;
        end
        check("timeout_wait_cycles", n - 1, TIMEOUT);
        check("timeout_cause", 32'(fault_cause), 32'(FC_TIMEOUT));
        check("timeout_pc", pc, RST_PC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
